// File: rtl/line_fill_if.sv
// line_fill_if: miss request, cache array and banked memory signals of the line fill controller
interface line_fill_if;
  logic        miss_start;
  logic        dirty;
  logic [4:0]  victim_tag;
  logic [4:0]  req_tag;
  logic [7:0]  index;
  logic [15:0] wb_data;
  logic [15:0] mem_data_in;
  logic        mem_stall;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_out;
  logic [2:0]  cache_offset;
  logic        cache_wr;
  logic [15:0] fill_data;
  logic [4:0]  tag_out;
  logic        busy;
  logic        done;
  modport master (
    input  miss_start, dirty, victim_tag, req_tag, index, wb_data, mem_data_in, mem_stall,
    output mem_addr, mem_rd, mem_wr, mem_data_out, cache_offset, cache_wr, fill_data, tag_out, busy, done
  );
  modport slave (
    output miss_start, dirty, victim_tag, req_tag, index, wb_data, mem_data_in, mem_stall,
    input  mem_addr, mem_rd, mem_wr, mem_data_out, cache_offset, cache_wr, fill_data, tag_out, busy, done
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: cache miss controller doing optional victim write-back, then line read and fill
module line_fill_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  line_fill_if.master bus
);
  typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [2:0] fills;
  logic [4:0] vtag, rtag;
  logic [7:0] idx;
  logic [MEM_LAT-1:0] pv;
  logic [1:0] po [MEM_LAT];
  logic acc, last, fill, fills_done;
  assign acc = (bus.mem_rd | bus.mem_wr) & ~bus.mem_stall;
  assign last = cnt == 2'(WORDS - 1);
  assign fill = pv[MEM_LAT-1];
  assign fills_done = (fills + 3'(fill)) == 3'(WORDS);
  assign bus.mem_wr = state == WB;
  assign bus.mem_rd = state == RD;
  assign bus.mem_addr = bus.mem_wr ? {vtag, idx, cnt, 1'b0} : bus.mem_rd ? {rtag, idx, cnt, 1'b0} : 16'h0;
  assign bus.mem_data_out = bus.mem_wr ? bus.wb_data : 16'h0;
  assign bus.cache_wr = fill;
  assign bus.cache_offset = fill ? {po[MEM_LAT-1], 1'b0} : bus.mem_wr ? {cnt, 1'b0} : 3'd0;
  assign bus.fill_data = bus.mem_data_in;
  assign bus.tag_out = rtag;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.miss_start ? (bus.dirty ? WB : RD) : IDLE;
      WB:      state_nx = (acc && last) ? RD : WB;
      RD:      state_nx = fills_done ? DONE : (acc && last) ? DRAIN : RD;
      DRAIN:   state_nx = fills_done ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // The return pipeline shifts every cycle so fills keep their fixed latency through stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      fills <= 3'd0;
      vtag <= 5'd0;
      rtag <= 5'd0;
      idx <= 8'd0;
      pv <= '0;
      for (int i = 0; i < MEM_LAT; i++) po[i] <= 2'd0;
    end else begin
      state <= state_nx;
      if (acc) cnt <= cnt + 2'd1;
      fills <= (state == DONE) ? 3'd0 : fills + 3'(fill);
      if (state == IDLE && bus.miss_start) begin
        vtag <= bus.victim_tag;
        rtag <= bus.req_tag;
        idx <= bus.index;
      end
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
      pv[0] <= bus.mem_rd & ~bus.mem_stall;
      po[0] <= cnt;
    end
  end
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: directed checks of miss handling, write-back, stalls, reset and back-to-back misses
module tb_line_fill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] ra1 = 16'h0;
  logic [15:0] ra2 = 16'h0;
  line_fill_if bus();
  line_fill_ctrl #(.MEM_LAT(2), .WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // memory returns A000+offset two cycles after an accepted read
  always @(posedge clk) begin
    ra1 <= (bus.mem_rd && !bus.mem_stall) ? bus.mem_addr : 16'h0;
    ra2 <= ra1;
  end
  assign bus.mem_data_in = 16'hA000 + {13'd0, ra2[2:0]};
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic expect_cyc(input string t, input bit rd, input bit wr, input logic [15:0] addr,
                            input bit cw, input logic [2:0] off, input logic [15:0] fd,
                            input bit dn, input bit bz);
    chk({t, ".mem_rd"}, 32'(bus.mem_rd), 32'(rd));
    chk({t, ".mem_wr"}, 32'(bus.mem_wr), 32'(wr));
    chk({t, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({t, ".cache_wr"}, 32'(bus.cache_wr), 32'(cw));
    chk({t, ".cache_offset"}, 32'(bus.cache_offset), 32'(off));
    chk({t, ".done"}, 32'(bus.done), 32'(dn));
    chk({t, ".busy"}, 32'(bus.busy), 32'(bz));
    if (cw) chk({t, ".fill_data"}, 32'(bus.fill_data), 32'(fd));
    if (wr) chk({t, ".mem_data_out"}, 32'(bus.mem_data_out), 32'hBEEF);
  endtask
  task automatic start(input logic d, input logic [4:0] vt, input logic [4:0] rt, input logic [7:0] ix);
    bus.miss_start = 1'b1;
    bus.dirty = d;
    bus.victim_tag = vt;
    bus.req_tag = rt;
    bus.index = ix;
    chk("start.busy", 32'(bus.busy), 32'd0);
    tick;
    bus.miss_start = 1'b0;
  endtask
  task automatic clean_seq(input string t, input logic [15:0] base, input int pulse_at);
    for (int c = 1; c <= 7; c++) begin
      bus.miss_start = (c == pulse_at);
      if (c == pulse_at) begin
        bus.dirty = 1'b1;
        bus.req_tag = 5'h1F;
        bus.victim_tag = 5'h0A;
      end
      expect_cyc($sformatf("%s.c%0d", t, c), c <= 4, 1'b0, c <= 4 ? base + 16'(2 * (c - 1)) : 16'h0,
                 c >= 3 && c <= 6, (c >= 3 && c <= 6) ? 3'(2 * (c - 3)) : 3'd0,
                 16'hA000 + 16'(2 * (c - 3)), c == 7, 1'b1);
      if (c == 5) chk({t, ".tag_out"}, 32'(bus.tag_out), 32'(base[15:11]));
      tick;
    end
    bus.miss_start = 1'b0;
  endtask
  initial begin
    bus.miss_start = 1'b0;
    bus.dirty = 1'b0;
    bus.victim_tag = 5'h0;
    bus.req_tag = 5'h0;
    bus.index = 8'h0;
    bus.wb_data = 16'hBEEF;
    bus.mem_stall = 1'b0;
    tick;
    tick;
    expect_cyc("reset", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    expect_cyc("idle", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    start(1'b0, 5'h00, 5'h03, 8'h2A);
    clean_seq("clean", 16'h1950, 0);
    start(1'b1, 5'h1F, 5'h02, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      expect_cyc($sformatf("dirty.c%0d", c), c >= 5 && c <= 8, c <= 4,
                 c <= 4 ? 16'hF800 + 16'(2 * (c - 1)) : (c <= 8 ? 16'h1000 + 16'(2 * (c - 5)) : 16'h0),
                 c >= 7 && c <= 10,
                 (c >= 7 && c <= 10) ? 3'(2 * (c - 7)) : (c <= 4 ? 3'(2 * (c - 1)) : 3'd0),
                 16'hA000 + 16'(2 * (c - 7)), c == 11, c <= 11);
      tick;
    end
    start(1'b0, 5'h00, 5'h03, 8'h2A);
    for (int c = 1; c <= 10; c++) begin
      bus.mem_stall = (c == 2 || c == 3);
      expect_cyc($sformatf("stall.c%0d", c), c <= 6, 1'b0,
                 c == 1 ? 16'h1950 : c <= 4 ? 16'h1952 : c == 5 ? 16'h1954 : c == 6 ? 16'h1956 : 16'h0,
                 c == 3 || (c >= 6 && c <= 8), c == 3 ? 3'd0 : (c >= 6 && c <= 8) ? 3'(2 * (c - 5)) : 3'd0,
                 c == 3 ? 16'hA000 : 16'hA000 + 16'(2 * (c - 5)), c == 9, c <= 9);
      tick;
    end
    bus.mem_stall = 1'b0;
    start(1'b0, 5'h00, 5'h03, 8'h2A);
    clean_seq("ignore", 16'h1950, 3);
    for (int c = 8; c <= 10; c++) begin
      expect_cyc($sformatf("ignore.c%0d", c), 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      tick;
    end
    start(1'b0, 5'h00, 5'h03, 8'h2A);
    clean_seq("b2b1", 16'h1950, 0);
    start(1'b0, 5'h00, 5'h04, 8'h10);
    clean_seq("b2b2", 16'h2080, 0);
    start(1'b0, 5'h00, 5'h03, 8'h2A);
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      expect_cyc($sformatf("midrst.c%0d", c), 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      tick;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
